// File: rtl/wb_burst_fetcher_if.sv
// Wishbone classic/burst read-master bus bundle for wb_burst_fetcher.
// The master modport is the fetcher side; the slave modport is the memory side.
interface wb_burst_fetcher_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [29:0] wbm_addr_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic [31:0] wbm_data_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o, wbm_sel_o, wbm_we_o,
        input  wbm_data_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o, wbm_sel_o, wbm_we_o,
        output wbm_data_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_burst_fetcher.sv
// Wishbone incrementing-burst read engine feeding a first-word-fall-through FIFO.
// A burst only starts once the FIFO has room for every beat of it, so the FIFO cannot overflow.
module wb_burst_fetcher #(
    parameter int BURST_LEN      = 8,
    parameter int FIFO_ADDR_BITS = 4,
    parameter int CNT_BITS       = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [29:0]         start_addr,
    input  logic [CNT_BITS-1:0] word_cnt,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                rd_en,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    wb_burst_fetcher_if.master  wbm
);

    localparam int DEPTH  = 1 << FIFO_ADDR_BITS;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SPACE = 2'd1,
        S_BURST      = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    cyc_q;
    logic                    stb_q;
    logic [29:0]             addr_q;
    logic [2:0]              cti_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [CNT_BITS-1:0]     remaining_q;
    logic [BEAT_W-1:0]       beats_q;

    logic [31:0]             mem_q [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q;
    logic [FIFO_ADDR_BITS:0]   count_q;
    logic [FIFO_ADDR_BITS:0]   count_d;

    logic        push_s;
    logic        pop_s;
    logic        flush_s;
    logic [31:0] burst_len_s;
    logic [31:0] free_s;

    assign push_s  = (state_q == S_BURST) && cyc_q && wbm.wbm_ack_i && !wbm.wbm_err_i;
    assign pop_s   = rd_en && (count_q != {(FIFO_ADDR_BITS+1){1'b0}});
    assign flush_s = (state_q == S_IDLE) && start;

    // Next burst length and FIFO free slots for the space check.
    always_comb begin
        free_s = 32'(DEPTH) - 32'(count_q);
        if (32'(remaining_q) < 32'(BURST_LEN)) begin
            burst_len_s = 32'(remaining_q);
        end else begin
            burst_len_s = 32'(BURST_LEN);
        end
    end

    // Occupancy next state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{FIFO_ADDR_BITS{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{FIFO_ADDR_BITS{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy, flushed when a new job is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {FIFO_ADDR_BITS{1'b0}};
            rd_ptr_q <= {FIFO_ADDR_BITS{1'b0}};
            count_q  <= {(FIFO_ADDR_BITS+1){1'b0}};
        end else if (flush_s) begin
            wr_ptr_q <= {FIFO_ADDR_BITS{1'b0}};
            rd_ptr_q <= {FIFO_ADDR_BITS{1'b0}};
            count_q  <= {(FIFO_ADDR_BITS+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_q + FIFO_ADDR_BITS'(push_s);
            rd_ptr_q <= rd_ptr_q + FIFO_ADDR_BITS'(pop_s);
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wbm.wbm_data_i;
        end
    end

    // Job/burst sequencer with registered bus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            addr_q      <= 30'd0;
            cti_q       <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            remaining_q <= {CNT_BITS{1'b0}};
            beats_q     <= {BEAT_W{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= start_addr;
                        remaining_q <= word_cnt;
                        err_q       <= 1'b0;
                        if (word_cnt == {CNT_BITS{1'b0}}) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_WAIT_SPACE;
                        end
                    end
                end
                S_WAIT_SPACE: begin
                    if (free_s >= burst_len_s) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cti_q   <= (burst_len_s == 32'd1) ? 3'b111 : 3'b010;
                        beats_q <= BEAT_W'(burst_len_s);
                        state_q <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (wbm.wbm_err_i) begin
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        cti_q   <= 3'b000;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wbm.wbm_ack_i) begin
                        addr_q      <= addr_q + 30'd1;
                        remaining_q <= remaining_q - CNT_BITS'(1);
                        beats_q     <= beats_q - BEAT_W'(1);
                        if (beats_q == BEAT_W'(1)) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            cti_q <= 3'b000;
                            if (remaining_q == CNT_BITS'(1)) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_WAIT_SPACE;
                            end
                        end else if (beats_q == BEAT_W'(2)) begin
                            cti_q <= 3'b111;
                        end else begin
                            cti_q <= 3'b010;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    cti_q   <= 3'b000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wbm.wbm_cyc_o  = cyc_q;
    assign wbm.wbm_stb_o  = stb_q;
    assign wbm.wbm_addr_o = addr_q;
    assign wbm.wbm_cti_o  = cti_q;
    assign wbm.wbm_bte_o  = 2'b00;
    assign wbm.wbm_sel_o  = 4'b1111;
    assign wbm.wbm_we_o   = 1'b0;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != {(FIFO_ADDR_BITS+1){1'b0}});

endmodule

// File: tb/tb_wb_burst_fetcher.sv
// Directed bench for wb_burst_fetcher: a combinational slave returns an address-derived
// word, so every FIFO word and every logged beat has a hand-computable expected value.
module tb_wb_burst_fetcher;
    localparam int CNT_BITS = 20;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [29:0]         start_addr;
    logic [CNT_BITS-1:0] word_cnt;
    logic                busy;
    logic                done;
    logic                err;
    logic                rd_en;
    logic [31:0]         rd_data;
    logic                rd_valid;

    logic ack_gate;
    logic err_gate;
    int   err_beat;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [29:0] log_addr[$];
    logic [2:0]  log_cti[$];

    always #5 clk = ~clk;

    wb_burst_fetcher_if wb();

    assign wb.wbm_ack_i  = wb.wbm_cyc_o & wb.wbm_stb_o & ack_gate & ~err_gate;
    assign wb.wbm_err_i  = wb.wbm_cyc_o & wb.wbm_stb_o & err_gate;
    assign wb.wbm_data_i = {wb.wbm_addr_o, 2'b00} ^ 32'hC3C3_5A5A;

    wb_burst_fetcher #(.BURST_LEN(8), .FIFO_ADDR_BITS(4), .CNT_BITS(CNT_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wbm        (wb.master)
    );

    function automatic logic [31:0] exp_data(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hC3C3_5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already set; logs any accepted beat, returns at next negedge.
    task automatic cycle();
        err_gate = (err_beat != 0) && (log_addr.size() == err_beat - 1);
        #1;
        if (wb.wbm_cyc_o && wb.wbm_stb_o && wb.wbm_ack_i) begin
            log_addr.push_back(wb.wbm_addr_o);
            log_cti.push_back(wb.wbm_cti_o);
        end
        @(negedge clk);
    endtask

    task automatic start_job(input logic [29:0] a, input logic [CNT_BITS-1:0] n);
        log_addr.delete();
        log_cti.delete();
        start      = 1'b1;
        start_addr = a;
        word_cnt   = n;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            cycle();
            if (done) seen = 1'b1;
        end
    endtask

    task automatic pop_check(input string tag, input logic [29:0] a);
        check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_eq({tag, "_data"}, rd_data, exp_data(a));
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        bit          seen;
        bit          done_seen;
        int          idx;
        logic [29:0] base;

        rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; start_addr = 30'd0; word_cnt = '0;
        ack_gate = 1'b1; err_gate = 1'b0; err_beat = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        check_eq("rst_stb", 32'(wb.wbm_stb_o), 32'd0);
        check_eq("rst_cti", 32'(wb.wbm_cti_o), 32'd0);
        check_eq("rst_addr", 32'(wb.wbm_addr_o), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_valid", 32'(rd_valid), 32'd0);
        check_eq("const_sel", 32'(wb.wbm_sel_o), 32'hF);
        check_eq("const_we", 32'(wb.wbm_we_o), 32'd0);
        check_eq("const_bte", 32'(wb.wbm_bte_o), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Single full burst of 8 at 0x100
        start_job(30'h100, 20'd8);
        check_eq("b8_busy", 32'(busy), 32'd1);
        wait_done(40, seen);
        check_eq("b8_done", 32'(seen), 32'd1);
        check_eq("b8_cyc_at_done", 32'(wb.wbm_cyc_o), 32'd0);
        check_eq("b8_busy_at_done", 32'(busy), 32'd0);
        check_eq("b8_beats", 32'(log_addr.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check_eq("b8_addr", 32'(log_addr[i]), 32'h100 + 32'(i));
            check_eq("b8_cti", 32'(log_cti[i]), (i == 7) ? 32'd7 : 32'd2);
        end
        cycle();
        check_eq("b8_done_pulse", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) pop_check("b8_pop", 30'h100 + 30'(i));
        check_eq("b8_empty", 32'(rd_valid), 32'd0);

        // 20 words, no consumer: two bursts, stall, then a 4-beat tail after 4 pops
        start_job(30'h200, 20'd20);
        repeat (40) cycle();
        check_eq("s20_beats_stall", 32'(log_addr.size()), 32'd16);
        check_eq("s20_busy_stall", 32'(busy), 32'd1);
        check_eq("s20_cyc_stall", 32'(wb.wbm_cyc_o), 32'd0);
        for (int i = 0; i < 3; i++) pop_check("s20_pop", 30'h200 + 30'(i));
        check_eq("s20_still_stalled", 32'(log_addr.size()), 32'd16);
        pop_check("s20_pop", 30'h203);
        wait_done(40, seen);
        check_eq("s20_done", 32'(seen), 32'd1);
        check_eq("s20_beats", 32'(log_addr.size()), 32'd20);
        if (log_addr.size() == 20) begin
            check_eq("s20_cti7", 32'(log_cti[7]), 32'd7);
            check_eq("s20_cti8", 32'(log_cti[8]), 32'd2);
            check_eq("s20_cti15", 32'(log_cti[15]), 32'd7);
            for (int i = 16; i < 19; i++) check_eq("s20_tail_cti", 32'(log_cti[i]), 32'd2);
            check_eq("s20_tail_last_cti", 32'(log_cti[19]), 32'd7);
            check_eq("s20_tail_addr", 32'(log_addr[16]), 32'h210);
            check_eq("s20_last_addr", 32'(log_addr[19]), 32'h213);
        end
        for (int i = 4; i < 20; i++) pop_check("s20_pop", 30'h200 + 30'(i));
        check_eq("s20_empty", 32'(rd_valid), 32'd0);

        // Random wait states and pops, address wrapping past 2^30
        base = 30'h3FFF_FFFC;
        start_job(base, 20'd37);
        idx = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 3000 && !(done_seen && idx == 37); c++) begin
            ack_gate = 1'($urandom_range(0, 1));
            if (rd_valid && idx < 37 && $urandom_range(0, 1) == 1) begin
                check_eq("rnd_data", rd_data, exp_data(base + 30'(idx)));
                rd_en = 1'b1;
                idx++;
            end else begin
                rd_en = 1'b0;
            end
            cycle();
            if (done) begin
                done_seen = 1'b1;
                check_eq("rnd_beats_at_done", 32'(log_addr.size()), 32'd37);
            end
        end
        rd_en = 1'b0;
        ack_gate = 1'b1;
        check_eq("rnd_done", 32'(done_seen), 32'd1);
        check_eq("rnd_popped", 32'(idx), 32'd37);
        check_eq("rnd_empty", 32'(rd_valid), 32'd0);
        if (log_addr.size() > 4) begin
            check_eq("rnd_wrap_hi", 32'(log_addr[3]), 32'h3FFF_FFFF);
            check_eq("rnd_wrap_lo", 32'(log_addr[4]), 32'd0);
        end

        // Bus error on beat 3 of the first burst
        err_beat = 3;
        start_job(30'h400, 20'd8);
        seen = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (done) done_seen = 1'b1;
            if (err) seen = 1'b1;
        end
        check_eq("err_flag", 32'(seen), 32'd1);
        check_eq("err_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        check_eq("err_stb", 32'(wb.wbm_stb_o), 32'd0);
        check_eq("err_busy", 32'(busy), 32'd0);
        check_eq("err_no_done", 32'(done_seen | done), 32'd0);
        check_eq("err_beats", 32'(log_addr.size()), 32'd2);
        err_beat = 0;
        cycle();
        check_eq("err_sticky", 32'(err), 32'd1);
        pop_check("err_pop", 30'h400);
        pop_check("err_pop", 30'h401);
        check_eq("err_empty", 32'(rd_valid), 32'd0);

        // Zero-length job clears err and pulses done without a bus cycle
        start_job(30'h123, 20'd0);
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_err_cleared", 32'(err), 32'd0);
        check_eq("zero_busy", 32'(busy), 32'd0);
        check_eq("zero_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        cycle();
        check_eq("zero_done_pulse", 32'(done), 32'd0);
        check_eq("zero_no_beats", 32'(log_addr.size()), 32'd0);

        // Start while busy is ignored
        ack_gate = 1'b0;
        start_job(30'h500, 20'd4);
        repeat (3) cycle();
        check_eq("busy_stall_cyc", 32'(wb.wbm_cyc_o), 32'd1);
        start = 1'b1; start_addr = 30'h600; word_cnt = 20'd2;
        cycle();
        start = 1'b0;
        ack_gate = 1'b1;
        wait_done(40, seen);
        check_eq("busy_done", 32'(seen), 32'd1);
        check_eq("busy_beats", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            check_eq("busy_first_addr", 32'(log_addr[0]), 32'h500);
            check_eq("busy_last_addr", 32'(log_addr[3]), 32'h503);
            check_eq("busy_last_cti", 32'(log_cti[3]), 32'd7);
        end
        for (int i = 0; i < 4; i++) pop_check("busy_pop", 30'h500 + 30'(i));
        check_eq("busy_empty", 32'(rd_valid), 32'd0);

        // Asynchronous reset in the middle of a burst
        start_job(30'h700, 20'd8);
        cycle();
        cycle();
        check_eq("mid_cyc_before", 32'(wb.wbm_cyc_o), 32'd1);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        check_eq("mid_rst_stb", 32'(wb.wbm_stb_o), 32'd0);
        check_eq("mid_rst_cti", 32'(wb.wbm_cti_o), 32'd0);
        check_eq("mid_rst_addr", 32'(wb.wbm_addr_o), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        check_eq("post_rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_valid", 32'(rd_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
